// File: rtl/riscv_intc_pkg.sv
// Shared constants and types for the core interrupt controller and its platform gateway.
package riscv_intc_pkg;

    localparam int NUMINT = 16;

    localparam logic [1:0] INTC_CFG_ENABLE  = 2'd0;
    localparam logic [1:0] INTC_CFG_EDGE    = 2'd1;
    localparam logic [1:0] INTC_CFG_PENDING = 2'd2;
    localparam logic [1:0] INTC_CFG_STATUS  = 2'd3;

    typedef enum logic {
        GW_IDLE   = 1'b0,
        GW_ACTIVE = 1'b1
    } intc_gw_state_t;

endpackage

// File: rtl/riscv_irq_sync.sv
// Multi-flop synchroniser for a vector of asynchronous lines; each bit is independent.
module riscv_irq_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] synced
);

    logic [STAGES-1:0][WIDTH-1:0] stage_reg;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            stage_reg <= '0;
        end else begin
            stage_reg <= {stage_reg[STAGES-2:0], raw};
        end
    end

    assign synced = stage_reg[STAGES-1];

endmodule

// File: rtl/riscv_irq_gateway.sv
// Interrupt gateway: synchronises and captures peripheral IRQs, masks them and
// serialises claim/complete so only one source is in service at a time.
module riscv_irq_gateway
    import riscv_intc_pkg::*;
#(
    parameter int NUMINT      = riscv_intc_pkg::NUMINT,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic [NUMINT-1:0]         irq_src_i,
    input  logic                      cfg_we_i,
    input  logic [1:0]                cfg_addr_i,
    input  logic [NUMINT-1:0]         cfg_wdata_i,
    output logic [NUMINT-1:0]         cfg_rdata_o,
    output logic [NUMINT-1:0]         ext_int_o,
    input  logic                      claim_i,
    output logic [$clog2(NUMINT)-1:0] claim_id_o,
    output logic                      claim_valid_o,
    input  logic                      complete_i,
    input  logic [$clog2(NUMINT)-1:0] complete_id_i,
    output logic                      busy_o
);

    localparam int IDW = $clog2(NUMINT);

    function automatic logic [IDW-1:0] lowest_index(input logic [NUMINT-1:0] vec);
        lowest_index = '0;
        for (int i = NUMINT - 1; i >= 0; i--) begin
            if (vec[i]) lowest_index = IDW'(i);
        end
    endfunction

    logic [NUMINT-1:0] sync_level;
    logic [NUMINT-1:0] prev_reg;
    logic [NUMINT-1:0] enable_reg;
    logic [NUMINT-1:0] edge_reg;
    logic [NUMINT-1:0] pending_reg;
    logic [NUMINT-1:0] pending_next;
    logic [NUMINT-1:0] armed_reg;
    logic [NUMINT-1:0] armed_next;
    logic [NUMINT-1:0] set_vec;
    logic [NUMINT-1:0] request;
    logic [NUMINT-1:0] sw_clr;
    logic [NUMINT-1:0] claim_mask;
    logic [NUMINT-1:0] complete_mask;
    logic [IDW-1:0]    in_service_id_reg;
    intc_gw_state_t    state_reg;
    logic              is_idle;
    logic              do_claim;
    logic              do_complete;

    riscv_irq_sync #(
        .WIDTH (NUMINT),
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i (clk_i),
        .rstn_i(rstn_i),
        .raw   (irq_src_i),
        .synced(sync_level)
    );

    // A disarmed source (claimed, not yet completed) ignores its line entirely.
    for (genvar gi = 0; gi < NUMINT; gi++) begin : g_capture
        assign set_vec[gi] = armed_reg[gi] &
                             (edge_reg[gi] ? (sync_level[gi] & ~prev_reg[gi]) : sync_level[gi]);
    end

    assign is_idle       = (state_reg == GW_IDLE);
    assign busy_o        = (state_reg == GW_ACTIVE);
    assign request       = pending_reg & enable_reg;
    assign claim_valid_o = is_idle & (|request);
    assign claim_id_o    = lowest_index(request);
    assign ext_int_o     = is_idle ? request : '0;

    assign do_claim      = claim_i & claim_valid_o;
    assign do_complete   = busy_o & complete_i & (complete_id_i == in_service_id_reg);
    assign claim_mask    = do_claim ? (NUMINT'(1) << claim_id_o) : '0;
    assign complete_mask = do_complete ? (NUMINT'(1) << in_service_id_reg) : '0;
    assign sw_clr        = (cfg_we_i && cfg_addr_i == INTC_CFG_PENDING) ? cfg_wdata_i : '0;

    // Hardware set beats a software clear; the claim clear beats both.
    assign pending_next  = ((pending_reg & ~sw_clr) | set_vec) & ~claim_mask;
    assign armed_next    = (armed_reg & ~claim_mask) | complete_mask;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            prev_reg    <= '0;
            pending_reg <= '0;
            armed_reg   <= '1;
            enable_reg  <= '0;
            edge_reg    <= '0;
        end else begin
            prev_reg    <= sync_level;
            pending_reg <= pending_next;
            armed_reg   <= armed_next;
            if (cfg_we_i && cfg_addr_i == INTC_CFG_ENABLE) enable_reg <= cfg_wdata_i;
            if (cfg_we_i && cfg_addr_i == INTC_CFG_EDGE)   edge_reg   <= cfg_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg         <= GW_IDLE;
            in_service_id_reg <= '0;
        end else begin
            case (state_reg)
                GW_IDLE: begin
                    if (do_claim) begin
                        state_reg         <= GW_ACTIVE;
                        in_service_id_reg <= claim_id_o;
                    end
                end
                GW_ACTIVE: begin
                    if (do_complete) state_reg <= GW_IDLE;
                end
                default: state_reg <= GW_IDLE;
            endcase
        end
    end

    always_comb begin
        cfg_rdata_o = '0;
        case (cfg_addr_i)
            INTC_CFG_ENABLE:  cfg_rdata_o = enable_reg;
            INTC_CFG_EDGE:    cfg_rdata_o = edge_reg;
            INTC_CFG_PENDING: cfg_rdata_o = pending_reg;
            INTC_CFG_STATUS:  cfg_rdata_o = NUMINT'({busy_o, in_service_id_reg});
            default:          cfg_rdata_o = '0;
        endcase
    end

endmodule

// File: tb/tb_riscv_irq_gateway.sv
// Directed bench for riscv_irq_gateway: capture latency, claim/complete, masking, gating and reset.
module tb_riscv_irq_gateway;

    localparam int N   = 16;
    localparam int IDW = 4;

    logic           clk_i = 1'b0;
    logic           rstn_i;
    logic [N-1:0]   irq_src_i;
    logic           cfg_we_i;
    logic [1:0]     cfg_addr_i;
    logic [N-1:0]   cfg_wdata_i;
    logic [N-1:0]   cfg_rdata_o;
    logic [N-1:0]   ext_int_o;
    logic           claim_i;
    logic [IDW-1:0] claim_id_o;
    logic           claim_valid_o;
    logic           complete_i;
    logic [IDW-1:0] complete_id_i;
    logic           busy_o;

    int vectors     = 0;
    int miscompares = 0;

    riscv_irq_gateway dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .irq_src_i    (irq_src_i),
        .cfg_we_i     (cfg_we_i),
        .cfg_addr_i   (cfg_addr_i),
        .cfg_wdata_i  (cfg_wdata_i),
        .cfg_rdata_o  (cfg_rdata_o),
        .ext_int_o    (ext_int_o),
        .claim_i      (claim_i),
        .claim_id_o   (claim_id_o),
        .claim_valid_o(claim_valid_o),
        .complete_i   (complete_i),
        .complete_id_i(complete_id_i),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [N-1:0] data);
        cfg_we_i    = 1'b1;
        cfg_addr_i  = addr;
        cfg_wdata_i = data;
        step();
        cfg_we_i    = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] addr, output logic [N-1:0] data);
        cfg_addr_i = addr;
        #1;
        data = cfg_rdata_o;
    endtask

    task automatic pulse_irq(input logic [N-1:0] mask);
        irq_src_i = irq_src_i | mask;
        step();
        irq_src_i = irq_src_i & ~mask;
    endtask

    task automatic claim_now();
        claim_i = 1'b1;
        step();
        claim_i = 1'b0;
    endtask

    task automatic complete_now(input logic [IDW-1:0] id);
        complete_i    = 1'b1;
        complete_id_i = id;
        step();
        complete_i    = 1'b0;
    endtask

    logic [N-1:0] rd;

    initial begin
        rstn_i        = 1'b0;
        irq_src_i     = '0;
        cfg_we_i      = 1'b0;
        cfg_addr_i    = 2'd0;
        cfg_wdata_i   = '0;
        claim_i       = 1'b0;
        complete_i    = 1'b0;
        complete_id_i = '0;

        // Reset state
        step(3);
        check_val("rst_ext_int", 32'(ext_int_o), 32'h0);
        check_val("rst_claim_valid", 32'(claim_valid_o), 32'h0);
        check_val("rst_busy", 32'(busy_o), 32'h0);
        read_reg(2'd0, rd);
        check_val("rst_enable", 32'(rd), 32'h0);
        rstn_i = 1'b1;
        step();

        // Edge capture and 3-cycle latency
        cfg_write(2'd0, 16'h0001);
        cfg_write(2'd1, 16'h0001);
        pulse_irq(16'h0001);
        step();
        check_val("edge_lat2_ext_int", 32'(ext_int_o), 32'h0);
        step();
        check_val("edge_lat3_ext_int", 32'(ext_int_o), 32'h0001);
        check_val("edge_claim_id", 32'(claim_id_o), 32'h0);
        check_val("edge_claim_valid", 32'(claim_valid_o), 32'h1);

        // Claim, mismatched complete, matching complete
        claim_now();
        check_val("claim_busy", 32'(busy_o), 32'h1);
        check_val("claim_ext_int", 32'(ext_int_o), 32'h0);
        read_reg(2'd2, rd);
        check_val("claim_pending", 32'(rd), 32'h0);
        read_reg(2'd3, rd);
        check_val("claim_status", 32'(rd), 32'h0010);
        complete_now(4'd3);
        check_val("bad_complete_busy", 32'(busy_o), 32'h1);
        complete_now(4'd0);
        check_val("complete_busy", 32'(busy_o), 32'h0);
        read_reg(2'd3, rd);
        check_val("complete_status", 32'(rd), 32'h0);

        // Priority and masking
        cfg_write(2'd1, 16'h0024);
        cfg_write(2'd0, 16'h0020);
        pulse_irq(16'h0024);
        step(2);
        check_val("mask_claim_id", 32'(claim_id_o), 32'h5);
        check_val("mask_ext_int", 32'(ext_int_o), 32'h0020);
        read_reg(2'd2, rd);
        check_val("mask_pending", 32'(rd), 32'h0024);
        cfg_write(2'd0, 16'h0024);
        check_val("prio_claim_id", 32'(claim_id_o), 32'h2);
        check_val("prio_ext_int", 32'(ext_int_o), 32'h0024);
        cfg_write(2'd2, 16'h0024);
        read_reg(2'd2, rd);
        check_val("w1c_pending", 32'(rd), 32'h0);
        check_val("w1c_claim_valid", 32'(claim_valid_o), 32'h0);

        // Level source: dropped during service, re-pends after complete
        cfg_write(2'd1, 16'h0000);
        cfg_write(2'd0, 16'h0010);
        irq_src_i[4] = 1'b1;
        step(3);
        check_val("lvl_claim_id", 32'(claim_id_o), 32'h4);
        claim_now();
        check_val("lvl_busy", 32'(busy_o), 32'h1);
        irq_src_i[4] = 1'b0;
        step();
        irq_src_i[4] = 1'b1;
        step(4);
        read_reg(2'd2, rd);
        check_val("lvl_active_pending", 32'(rd), 32'h0);
        complete_now(4'd4);
        read_reg(2'd2, rd);
        check_val("lvl_at_complete_pending", 32'(rd), 32'h0);
        step();
        read_reg(2'd2, rd);
        check_val("lvl_repend_pending", 32'(rd), 32'h0010);
        check_val("lvl_repend_ext_int", 32'(ext_int_o), 32'h0010);
        irq_src_i[4] = 1'b0;
        step(3);
        cfg_write(2'd2, 16'h0010);
        read_reg(2'd2, rd);
        check_val("lvl_clear_pending", 32'(rd), 32'h0);

        // Edge source: in-service edge lost
        cfg_write(2'd1, 16'h0010);
        pulse_irq(16'h0010);
        step(2);
        check_val("edg4_claim_valid", 32'(claim_valid_o), 32'h1);
        claim_now();
        pulse_irq(16'h0010);
        step(4);
        complete_now(4'd4);
        step();
        read_reg(2'd2, rd);
        check_val("edg4_lost_pending", 32'(rd), 32'h0);
        check_val("edg4_busy", 32'(busy_o), 32'h0);

        // W1C racing a new edge on source 3: set wins
        cfg_write(2'd1, 16'h0008);
        cfg_write(2'd0, 16'h0008);
        irq_src_i[3] = 1'b1;
        step(2);
        cfg_write(2'd2, 16'h0008);
        read_reg(2'd2, rd);
        check_val("race_pending", 32'(rd), 32'h0008);
        irq_src_i[3] = 1'b0;

        // Claim and complete together in IDLE: claim only
        claim_i       = 1'b1;
        complete_i    = 1'b1;
        complete_id_i = 4'd3;
        step();
        claim_i    = 1'b0;
        complete_i = 1'b0;
        check_val("both_busy", 32'(busy_o), 32'h1);
        read_reg(2'd3, rd);
        check_val("both_status", 32'(rd), 32'h0013);
        complete_now(4'd3);
        check_val("both_done_busy", 32'(busy_o), 32'h0);

        // Asynchronous reset mid-service
        pulse_irq(16'h0008);
        step(2);
        claim_now();
        check_val("prereset_busy", 32'(busy_o), 32'h1);
        cfg_addr_i = 2'd0;
        #2;
        rstn_i = 1'b0;
        #1;
        check_val("async_busy", 32'(busy_o), 32'h0);
        check_val("async_ext_int", 32'(ext_int_o), 32'h0);
        check_val("async_claim_valid", 32'(claim_valid_o), 32'h0);
        check_val("async_enable", 32'(cfg_rdata_o), 32'h0);
        step(2);
        rstn_i = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/riscv_irq_gateway.md
Name: riscv_irq_gateway

Overview:
- Platform-side interrupt gateway and claim/complete sequencer that drives the core interrupt controller's ext_int_i bus.
- Synchronises raw interrupt lines and captures them as level or rising-edge requests into pending bits.
- Masks pending bits with per-source enables and serialises service: exactly one source is in service until software completes it.
- Sits between peripheral IRQ lines and the core, with a small config register port on the core's peripheral bus.

Parameters:
- NUMINT, riscv_intc_pkg::NUMINT (16): number of external interrupt sources.
- SYNC_STAGES, 2: synchroniser flops per source, minimum 2.
- IDW, $clog2(NUMINT): source ID width, a localparam.

Ports:
- clk_i  in  1  core clock
- rstn_i  in  1  asynchronous active-low reset
- irq_src_i  in  NUMINT  raw peripheral interrupt lines, asynchronous
- cfg_we_i  in  1  config write strobe
- cfg_addr_i  in  2  register select: 0 ENABLE, 1 EDGE, 2 PENDING, 3 STATUS
- cfg_wdata_i  in  NUMINT  config write data
- cfg_rdata_o  out  NUMINT  combinational read of the selected register
- ext_int_o  out  NUMINT  request vector to the core interrupt controller
- claim_i  in  1  one-cycle pulse: core has entered the handler for claim_id_o
- claim_id_o  out  IDW  lowest-index pending-and-enabled source
- claim_valid_o  out  1  claim_id_o is meaningful
- complete_i  in  1  one-cycle pulse: handler finished
- complete_id_i  in  IDW  ID being completed
- busy_o  out  1  a source is in service (state ACTIVE)

Behaviour:
- Reset (asynchronous, active-low): synchronisers, edge history, pending, enable and edge registers all 0. armed is all 1. State is IDLE with in_service_id 0. ext_int_o, claim_valid_o and busy_o are 0.
- Synchroniser: SYNC_STAGES flops per line. Edge history holds the previous synchronised value.
- Edge mode (EDGE[i]=1): a synchronised 0->1 with armed[i]=1 sets pending[i].
- Level mode (EDGE[i]=0): pending[i] is set whenever the synchronised level is 1 and armed[i]=1.
- Latency: a raw rise reaches ext_int_o in SYNC_STAGES+1 cycles (3 at default), provided the source is enabled and the state is IDLE.
- ext_int_o = pending & ENABLE while IDLE; all 0 while ACTIVE (no nesting).
- Disabled sources still latch pending but are never forwarded.
- claim_id_o is the lowest set index of pending & ENABLE, matching the core encoding cause = 0x80000010 + id. claim_valid_o = |(pending & ENABLE) and state IDLE.
- FSM IDLE -> ACTIVE on claim_i while claim_valid_o=1. In that cycle:
  - in_service_id <= claim_id_o
  - pending[id] <= 0
  - armed[id] <= 0
- claim_i while claim_valid_o=0 is ignored.
- FSM ACTIVE -> IDLE on complete_i with complete_id_i == in_service_id; armed[id] <= 1.
- Mismatched complete_i in ACTIVE, and any complete_i in IDLE, are ignored with no state change.
- Edges arriving while armed[i]=0 are dropped. A level source that is still high re-pends one cycle after complete.
- Other sources keep capturing while ACTIVE and are presented after return to IDLE.
- Config writes:
  - ENABLE and EDGE are written directly and take effect the next cycle.
  - PENDING is write-1-to-clear. A same-cycle hardware set wins over the clear.
  - STATUS is read-only: {busy_o, in_service_id} zero-extended.
- claim_i and complete_i in the same cycle: in IDLE, apply the claim only; in ACTIVE, apply the complete only.
- Reset asserted mid-service returns to IDLE with all pending lost.

Decomposition:
- riscv_intc_pkg gains:
  - config address constants INTC_CFG_ENABLE, INTC_CFG_EDGE, INTC_CFG_PENDING, INTC_CFG_STATUS
  - the FSM enum intc_gw_state_t {GW_IDLE, GW_ACTIVE}
- One sub-module, riscv_irq_sync: a parameterised SYNC_STAGES flop chain with asynchronous reset, instantiated once across the NUMINT-wide vector.
- The priority encoder is a local function; top-level RTL is about 200 lines.

Test Plan:
- Edge capture:
  - Stimulus: ENABLE=0x0001, EDGE=0x0001; pulse irq_src_i[0] for 1 cycle.
  - Response: ext_int_o=0x0001 exactly 3 cycles after the rise; claim_id_o=0, claim_valid_o=1.
- Claim/complete:
  - Stimulus: from the previous state, claim_i.
  - Response: next cycle busy_o=1, ext_int_o=0, pending[0]=0. Then complete_i with id 0 gives busy_o=0.
  - Stimulus: complete_i with id 3 instead.
  - Response: busy_o stays 1.
- Priority and masking:
  - Stimulus: sources 5 and 2 pending with ENABLE=0x0020.
  - Response: claim_id_o=5.
  - Stimulus: set ENABLE=0x0024.
  - Response: the next cycle claim_id_o=2.
- Gateway dropping and level re-pend:
  - Stimulus: level source 4 held high; claim it; pulse irq 4 during service.
  - Response: no pending while ACTIVE; pending[4] reasserts 1 cycle after complete while the line stays high.
  - Stimulus: same sequence with source 4 in edge mode.
  - Response: the in-service edge is lost and pending[4]=0 after complete.
- Software clear and races:
  - Stimulus: W1C PENDING=0x0008 in the same cycle as a new edge on source 3.
  - Response: pending[3] remains 1.
  - Stimulus: claim_i and complete_i together in IDLE.
  - Response: only the claim takes effect.
- Asynchronous reset:
  - Stimulus: assert rstn_i mid-ACTIVE, between clock edges.
  - Response: immediately busy_o=0, ext_int_o=0, claim_valid_o=0, ENABLE reads 0.
